// File: rtl/eq_pkg.sv
// Shared types and constants for the histogram-equalization engine.
package eq_pkg;

   localparam int unsigned BINS  = 256;
   localparam int unsigned PIX_W = 8;
   localparam int unsigned LUT_W = 8;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StScan,
      StDrain,
      StCdf,
      StDone
   } eq_state_t;

endpackage

// File: rtl/hist_bin_ram.sv
// 256-entry histogram bin store: one synchronous read port, one write port.
// A read colliding with a same-edge write returns the new value.
module hist_bin_ram
   import eq_pkg::*;
#(
   parameter int unsigned DATA_W = 17
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [PIX_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [PIX_W-1:0]  raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [BINS];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (we_i && (waddr_i == raddr_i)) begin
         rdata_q <= wdata_i;
      end else begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/hist_equalizer.sv
// Histogram-equalization engine: clears bins, scans the image ROM, accumulates
// the CDF and fills a 256x8 equalization LUT readable at any time.
module hist_equalizer
   import eq_pkg::*;
#(
   parameter int unsigned LOG2_PIXELS = 16,
   parameter int unsigned ADDR_W      = 16
) (
   input  logic              clk_50Mhz_in,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_data,
   input  logic [7:0]        lut_addr,
   output logic [7:0]        lut_data
);

   localparam int unsigned CNT_W  = LOG2_PIXELS + 1;
   localparam int unsigned PROD_W = LOG2_PIXELS + 9;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((2 ** LOG2_PIXELS) - 1);

   eq_state_t         state_q, state_d;
   logic [8:0]        idx_q, idx_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [CNT_W-1:0]  sum_q, sum_d;
   logic              s1_q, s2_q;
   logic [PIX_W-1:0]  pix2_q;
   logic [LUT_W-1:0]  lut_q [BINS];
   logic [LUT_W-1:0]  lut_data_q;

   logic              bin_we;
   logic [PIX_W-1:0]  bin_waddr, bin_raddr;
   logic [CNT_W-1:0]  bin_wdata, bin_rdata;
   logic [CNT_W-1:0]  sum_inc;
   logic [PROD_W-1:0] prod;
   logic              lut_we;
   logic [PIX_W-1:0]  lut_waddr;
   logic [LUT_W-1:0]  lut_wdata;

   hist_bin_ram #(
      .DATA_W (CNT_W)
   ) u_bins (
      .clk_i   (clk_50Mhz_in),
      .we_i    (bin_we),
      .waddr_i (bin_waddr),
      .wdata_i (bin_wdata),
      .raddr_i (bin_raddr),
      .rdata_o (bin_rdata)
   );

   assign sum_inc   = sum_q + bin_rdata;
   assign prod      = PROD_W'(sum_inc) * PROD_W'(255);
   assign lut_wdata = prod[LOG2_PIXELS +: LUT_W];
   // Bin read for v = idx-1 lands one cycle after its address was issued.
   assign lut_waddr = PIX_W'(idx_q - 9'd1);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rom_addr_d = rom_addr_q;
      sum_d      = sum_q;
      bin_we     = s2_q;
      bin_waddr  = pix2_q;
      bin_wdata  = bin_rdata + CNT_W'(1);
      bin_raddr  = s1_q ? rom_data[PIX_W-1:0] : idx_q[PIX_W-1:0];
      lut_we     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StClear;
               idx_d   = '0;
            end
         end
         StClear: begin
            bin_we    = 1'b1;
            bin_waddr = idx_q[PIX_W-1:0];
            bin_wdata = '0;
            idx_d     = idx_q + 9'd1;
            if (idx_q == 9'd255) begin
               state_d    = StScan;
               idx_d      = '0;
               rom_addr_d = '0;
            end
         end
         StScan: begin
            if (rom_addr_q == LAST_ADDR) begin
               state_d = StDrain;
            end else begin
               rom_addr_d = rom_addr_q + ADDR_W'(1);
            end
         end
         StDrain: begin
            idx_d = idx_q + 9'd1;
            if (idx_q == 9'd1) begin
               state_d = StCdf;
               idx_d   = '0;
               sum_d   = '0;
            end
         end
         StCdf: begin
            idx_d = idx_q + 9'd1;
            if (idx_q != 9'd0) begin
               sum_d  = sum_inc;
               lut_we = 1'b1;
            end
            if (idx_q == 9'd256) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_50Mhz_in or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         rom_addr_q <= '0;
         sum_q      <= '0;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         pix2_q     <= '0;
         lut_data_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rom_addr_q <= rom_addr_d;
         sum_q      <= sum_d;
         s1_q       <= (state_q == StScan);
         s2_q       <= s1_q;
         pix2_q     <= rom_data[PIX_W-1:0];
         lut_data_q <= lut_q[lut_addr];
      end
   end

   always_ff @(posedge clk_50Mhz_in) begin
      if (lut_we) begin
         lut_q[lut_waddr] <= lut_wdata;
      end
   end

   assign busy     = (state_q != StIdle) && (state_q != StDone);
   assign done     = (state_q == StDone);
   assign rom_addr = rom_addr_q;
   assign lut_data = lut_data_q;

   logic unused_bits;
   assign unused_bits = ^{rom_data[31:PIX_W], prod[PROD_W-1], prod[LOG2_PIXELS-1:0]};

endmodule

// File: tb/tb_hist_equalizer.sv
// Bench for hist_equalizer with a 16-pixel image, a 1-cycle ROM model and an
// arithmetic histogram/CDF reference.
module tb_hist_equalizer;

   localparam int unsigned L2      = 4;
   localparam int unsigned N       = 16;
   localparam int          EXP_CYC = N + 516;

   logic        clk = 1'b0;
   logic        reset, start;
   logic        busy, done;
   logic [15:0] rom_addr;
   logic [31:0] rom_data;
   logic [7:0]  lut_addr, lut_data;

   logic [7:0]  img [N];
   int          exp_lut [256];
   int          total = 0;
   int          bad   = 0;

   hist_equalizer #(
      .LOG2_PIXELS (L2),
      .ADDR_W      (16)
   ) dut (
      .clk_50Mhz_in (clk),
      .reset        (reset),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .lut_addr     (lut_addr),
      .lut_data     (lut_data)
   );

   always #5 clk = ~clk;

   // ROM port A: upper bits are noise the engine must ignore.
   always @(posedge clk) begin
      rom_data <= {8'($urandom), 8'($urandom), 8'($urandom), img[rom_addr[3:0]]};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   task automatic build_model();
      int hist [256];
      int sum;
      foreach (hist[v]) hist[v] = 0;
      for (int i = 0; i < N; i++) hist[img[i]] += 1;
      sum = 0;
      for (int v = 0; v < 256; v++) begin
         sum += hist[v];
         exp_lut[v] = (sum * 255) / N;
      end
   endtask

   task automatic read_lut(input int a, output logic [7:0] val);
      @(negedge clk);
      lut_addr = 8'(a);
      @(posedge clk);
      #1;
      val = lut_data;
   endtask

   task automatic check_lut(input string tag);
      logic [7:0] val;
      for (int v = 0; v < 256; v++) begin
         read_lut(v, val);
         check($sformatf("%s_lut%0d", tag, v), 32'(val), 32'(exp_lut[v]));
      end
   endtask

   task automatic run(input string tag, input int mid_start);
      int cyc;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_busy_start"}, 32'(busy), 32'd1);
      cyc = -1;
      for (int k = 1; k < 2000; k++) begin
         if (k == mid_start) start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) begin
            cyc = k + 1;
            break;
         end
      end
      check({tag, "_done_cycle"}, 32'(cyc), 32'(EXP_CYC));
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      logic [7:0] val;
      int         extra;
      reset    = 1'b0;
      start    = 1'b0;
      lut_addr = 8'd0;
      foreach (img[i]) img[i] = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_lut_data", 32'(lut_data), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Uniform image
      foreach (img[i]) img[i] = 8'h80;
      build_model();
      run("uni", 0);
      check_lut("uni");
      read_lut(127, val); check("uni_127", 32'(val), 32'd0);
      read_lut(128, val); check("uni_128", 32'(val), 32'd255);

      // Ramp
      foreach (img[i]) img[i] = 8'(16 * i);
      build_model();
      run("ramp", 0);
      check_lut("ramp");
      read_lut(0, val);   check("ramp_0", 32'(val), 32'd15);
      read_lut(15, val);  check("ramp_15", 32'(val), 32'd15);
      read_lut(112, val); check("ramp_112", 32'(val), 32'd127);
      read_lut(240, val); check("ramp_240", 32'(val), 32'd255);

      // Back-to-back repeated pixels
      img[0] = 8'd5; img[1] = 8'd5; img[2] = 8'd5; img[3] = 8'd7;
      img[4] = 8'd5; img[5] = 8'd7; img[6] = 8'd7; img[7] = 8'd5;
      for (int i = 8; i < N; i++) img[i] = 8'd0;
      build_model();
      run("fwd", 0);
      check_lut("fwd");
      read_lut(0, val); check("fwd_0", 32'(val), 32'd127);
      read_lut(5, val); check("fwd_5", 32'(val), 32'd207);
      read_lut(7, val); check("fwd_7", 32'(val), 32'd255);

      // Random images, full range and a narrow range that repeats heavily
      for (int r = 0; r < 3; r++) begin
         foreach (img[i]) img[i] = (r == 2) ? 8'($urandom_range(0, 3)) : 8'($urandom);
         build_model();
         run($sformatf("rnd%0d", r), 0);
         check_lut($sformatf("rnd%0d", r));
      end

      // Start pulsed mid-scan is ignored; rerun on same image matches
      foreach (img[i]) img[i] = 8'($urandom_range(10, 20));
      build_model();
      run("ign", 262);
      extra = 0;
      for (int k = 0; k < 600; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) extra++;
      end
      check("ign_no_extra_run", 32'(extra), 32'd0);
      check_lut("ign");
      run("rerun", 0);
      check_lut("rerun");

      // Reset mid-scan, then ramp restart
      foreach (img[i]) img[i] = 8'($urandom);
      run("pre", 0);
      foreach (img[i]) img[i] = 8'(16 * i);
      build_model();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (269) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      extra = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         if (done) extra++;
      end
      check("mid_rst_no_done", 32'(extra), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      run("restart", 0);
      check_lut("restart");

      // LUT read latency: address presented before edge k shows after edge k
      read_lut(0, val);
      @(negedge clk);
      lut_addr = 8'd240;
      #1;
      check("lat_before_edge", 32'(lut_data), 32'(exp_lut[0]));
      @(posedge clk);
      #1;
      check("lat_after_edge", 32'(lut_data), 32'd255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
